// File: rtl/array_mult_arb_if.sv
// Client-side bus of the shared-multiplier arbiter.
//   req        per-client request
//   lock       per-client burst lock
//   dataa      operand A vector per client
//   datab      operand B vector per client
//   gnt        one-hot grant (combinational)
//   rsp_valid  registered one-hot result strobe
//   rsp_result registered result, shared by all clients
//   busy       any operation in flight
// The master modport is the sub-block side; the slave modport is the arbiter.
interface array_mult_arb_if #(
    parameter int unsigned CLIENTS = 3,
    parameter int unsigned LANES   = 15,
    parameter int unsigned WIDTH   = 27
);
    logic [CLIENTS-1:0]                        req;
    logic [CLIENTS-1:0]                        lock;
    logic [CLIENTS-1:0][LANES-1:0][WIDTH-1:0] dataa;
    logic [CLIENTS-1:0][LANES-1:0][WIDTH-1:0] datab;
    logic [CLIENTS-1:0]                        gnt;
    logic [CLIENTS-1:0]                        rsp_valid;
    logic [LANES-1:0][WIDTH-1:0]               rsp_result;
    logic                                      busy;

    modport master (
        output req, lock, dataa, datab,
        input  gnt, rsp_valid, rsp_result, busy
    );

    modport slave (
        input  req, lock, dataa, datab,
        output gnt, rsp_valid, rsp_result, busy
    );
endinterface

// File: rtl/array_mult_arb.sv
// Round-robin arbiter (with burst lock) that time-shares one pipelined
// multiplier array among several sub-blocks. A granted client's operands are
// registered into the multiplier, a client tag travels alongside the fixed
// multiplier latency, and the result is strobed back to the issuing client.
// Ports:
//   clk, rst     clock; asynchronous active-low reset
//   en           global advance; 0 freezes all state and suppresses grants
//   cli          client bus (req/lock/dataa/datab in, gnt/rsp_*/busy out)
//   mult_dataa/b registered operands to the multiplier
//   mult_valid   mult_data* hold a live operation
//   mult_clken   multiplier clock enable (equals en)
//   mult_result  multiplier output, LAT enabled cycles after its operands
module array_mult_arb #(
    parameter int unsigned CLIENTS = 3,
    parameter int unsigned LANES   = 15,
    parameter int unsigned WIDTH   = 27,
    parameter int unsigned LAT     = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    array_mult_arb_if.slave             cli,
    output logic [LANES-1:0][WIDTH-1:0] mult_dataa,
    output logic [LANES-1:0][WIDTH-1:0] mult_datab,
    output logic                        mult_valid,
    output logic                        mult_clken,
    input  logic [LANES-1:0][WIDTH-1:0] mult_result
);
    localparam int unsigned CW = (CLIENTS > 1) ? $clog2(CLIENTS) : 1;

    typedef logic [CW-1:0]               cidx_t;
    typedef logic [LANES-1:0][WIDTH-1:0] vec_t;

    // Arbitration state
    cidx_t ptr_q, ptr_d;
    logic  last_vld_q, last_vld_d;
    cidx_t last_idx_q, last_idx_d;

    // Issue register (aligned with mult_data*) and tag pipeline behind it
    vec_t               mult_dataa_q, mult_dataa_d;
    vec_t               mult_datab_q, mult_datab_d;
    logic               issue_vld_q;
    cidx_t              issue_idx_q;
    logic  [LAT-1:0]    tag_vld_q;
    cidx_t [LAT-1:0]    tag_idx_q;

    // Response registers
    logic [CLIENTS-1:0] rsp_valid_q, rsp_valid_d;
    vec_t               rsp_result_q, rsp_result_d;

    // Grant decode
    logic               gnt_any;
    logic               gnt_locked;
    cidx_t              gnt_idx;
    logic [CLIENTS-1:0] gnt_vec;
    int unsigned        cand;

    always_comb begin
        gnt_any    = 1'b0;
        gnt_locked = 1'b0;
        gnt_idx    = '0;
        cand       = 0;
        if (en) begin
            if (last_vld_q && cli.lock[last_idx_q] && cli.req[last_idx_q]) begin
                gnt_any    = 1'b1;
                gnt_locked = 1'b1;
                gnt_idx    = last_idx_q;
            end else begin
                // First requester at or above the pointer, wrapping modulo CLIENTS
                for (int unsigned i = 0; i < CLIENTS; i++) begin
                    cand = (32'(ptr_q) + i) % CLIENTS;
                    if (!gnt_any && cli.req[cidx_t'(cand)]) begin
                        gnt_any = 1'b1;
                        gnt_idx = cidx_t'(cand);
                    end
                end
            end
        end
    end

    always_comb begin
        gnt_vec = '0;
        if (gnt_any) begin
            gnt_vec[gnt_idx] = 1'b1;
        end
    end

    // Next-state for arbitration, issue and response
    always_comb begin
        ptr_d        = ptr_q;
        last_vld_d   = 1'b0;
        last_idx_d   = last_idx_q;
        mult_dataa_d = mult_dataa_q;
        mult_datab_d = mult_datab_q;
        rsp_valid_d  = '0;
        rsp_result_d = rsp_result_q;

        if (gnt_any) begin
            last_vld_d   = 1'b1;
            last_idx_d   = gnt_idx;
            mult_dataa_d = cli.dataa[gnt_idx];
            mult_datab_d = cli.datab[gnt_idx];
            // A locked regrant leaves the round-robin pointer where it was
            if (!gnt_locked) begin
                ptr_d = (gnt_idx == cidx_t'(CLIENTS - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end

        if (tag_vld_q[LAT-1]) begin
            rsp_valid_d[tag_idx_q[LAT-1]] = 1'b1;
            rsp_result_d                  = mult_result;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q        <= '0;
            last_vld_q   <= 1'b0;
            last_idx_q   <= '0;
            mult_dataa_q <= '0;
            mult_datab_q <= '0;
            issue_vld_q  <= 1'b0;
            issue_idx_q  <= '0;
            tag_vld_q    <= '0;
            tag_idx_q    <= '0;
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
        end else if (en) begin
            ptr_q        <= ptr_d;
            last_vld_q   <= last_vld_d;
            last_idx_q   <= last_idx_d;
            mult_dataa_q <= mult_dataa_d;
            mult_datab_q <= mult_datab_d;
            issue_vld_q  <= gnt_any;
            issue_idx_q  <= gnt_idx;
            for (int unsigned i = LAT - 1; i > 0; i--) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_idx_q[i] <= tag_idx_q[i-1];
            end
            tag_vld_q[0] <= issue_vld_q;
            tag_idx_q[0] <= issue_idx_q;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
        end
    end

    assign cli.gnt        = gnt_vec;
    assign cli.rsp_valid  = rsp_valid_q;
    assign cli.rsp_result = rsp_result_q;
    assign cli.busy       = issue_vld_q | (|tag_vld_q);
    assign mult_dataa     = mult_dataa_q;
    assign mult_datab     = mult_datab_q;
    assign mult_valid     = issue_vld_q;
    assign mult_clken     = en;
endmodule

// File: tb/tb_array_mult_arb.sv
// Directed self-checking bench for array_mult_arb with a behavioural
// LAT-stage multiplier driven by mult_clken.
module tb_array_mult_arb;
    localparam int unsigned CLIENTS = 3;
    localparam int unsigned LANES   = 15;
    localparam int unsigned WIDTH   = 27;
    localparam int unsigned LAT     = 5;

    typedef logic [LANES-1:0][WIDTH-1:0] vec_t;

    logic clk;
    logic rst;
    logic en;
    vec_t mult_dataa;
    vec_t mult_datab;
    logic mult_valid;
    logic mult_clken;
    vec_t mult_result;

    int checks = 0;
    int errors = 0;
    int strobes;

    array_mult_arb_if #(.CLIENTS(CLIENTS), .LANES(LANES), .WIDTH(WIDTH)) cli ();

    array_mult_arb #(
        .CLIENTS(CLIENTS),
        .LANES  (LANES),
        .WIDTH  (WIDTH),
        .LAT    (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .cli        (cli),
        .mult_dataa (mult_dataa),
        .mult_datab (mult_datab),
        .mult_valid (mult_valid),
        .mult_clken (mult_clken),
        .mult_result(mult_result)
    );

    // Behavioural multiplier: lane-wise product, LAT enabled cycles deep
    vec_t prod;
    vec_t mpipe [LAT];

    always_comb begin
        prod = '0;
        for (int l = 0; l < LANES; l++) begin
            prod[l] = mult_dataa[l] * mult_datab[l];
        end
    end

    always_ff @(posedge clk) begin
        if (mult_clken) begin
            mpipe[0] <= prod;
            for (int i = 1; i < LAT; i++) begin
                mpipe[i] <= mpipe[i-1];
            end
        end
    end

    assign mult_result = mpipe[LAT-1];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [LANES*WIDTH-1:0] obs,
                         input logic [LANES*WIDTH-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic vec_t fill(input int unsigned v);
        vec_t r;
        for (int l = 0; l < LANES; l++) begin
            r[l] = WIDTH'(v);
        end
        return r;
    endfunction

    function automatic logic [CLIENTS-1:0] onehot(input int unsigned c);
        logic [CLIENTS-1:0] r;
        r    = '0;
        r[c] = 1'b1;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int unsigned c, input int unsigned a, input int unsigned b);
        for (int l = 0; l < LANES; l++) begin
            cli.dataa[c][l] = WIDTH'(a);
            cli.datab[c][l] = WIDTH'(b);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    initial begin
        rst       = 1'b0;
        en        = 1'b1;
        cli.req   = '0;
        cli.lock  = '0;
        cli.dataa = '0;
        cli.datab = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_mult_valid", mult_valid, 1'b0);
        check("reset_busy", cli.busy, 1'b0);
        check("reset_rsp_valid", cli.rsp_valid, 3'b000);
        check("reset_mult_dataa", mult_dataa, fill(0));
        check("reset_rsp_result", cli.rsp_result, fill(0));
        check("reset_gnt", cli.gnt, 3'b000);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Single client: grant at G, response at G+LAT+2
        set_ops(1, 3, 5);
        cli.req = 3'b010;
        #1;
        check("single_gnt", cli.gnt, 3'b010);
        tick();
        cli.req = '0;
        check("single_mult_valid", mult_valid, 1'b1);
        check("single_mult_dataa", mult_dataa, fill(3));
        check("single_busy", cli.busy, 1'b1);
        repeat (5) tick();
        check("single_rsp_early", cli.rsp_valid, 3'b000);
        tick();
        check("single_rsp_valid", cli.rsp_valid, 3'b010);
        check("single_rsp_result", cli.rsp_result, fill(15));
        tick();
        check("single_rsp_drop", cli.rsp_valid, 3'b000);
        check("single_idle_busy", cli.busy, 1'b0);

        // Round robin from pointer 0
        pulse_reset();
        for (int c = 0; c < CLIENTS; c++) begin
            set_ops(c, c + 1, 2);
        end
        for (int i = 0; i < 6; i++) begin
            cli.req = 3'b111;
            #1;
            check("rr_gnt", cli.gnt, onehot(i % 3));
            tick();
        end
        cli.req = '0;
        tick();
        for (int i = 0; i < 6; i++) begin
            check("rr_rsp_valid", cli.rsp_valid, onehot(i % 3));
            check("rr_rsp_result", cli.rsp_result, fill(2 * (i % 3 + 1)));
            tick();
        end
        check("rr_rsp_done", cli.rsp_valid, 3'b000);

        // Burst lock on client 0, then normal rotation resumes
        for (int i = 0; i < 4; i++) begin
            cli.req  = 3'b111;
            cli.lock = 3'b001;
            #1;
            check("lock_gnt", cli.gnt, 3'b001);
            tick();
        end
        cli.lock = '0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("unlock_gnt", cli.gnt, onehot((i + 1) % 3));
            tick();
        end
        // Locked client drops req: no regrant, plain RR from pointer 1
        cli.req  = 3'b110;
        cli.lock = 3'b001;
        #1;
        check("lock_req_drop", cli.gnt, 3'b010);
        tick();
        // Idle cycle clears last grant, so lock[1] cannot revive
        cli.req  = '0;
        cli.lock = '0;
        tick();
        cli.req  = 3'b111;
        cli.lock = 3'b010;
        #1;
        check("lock_after_idle", cli.gnt, 3'b100);
        tick();
        cli.req  = '0;
        cli.lock = '0;
        repeat (10) tick();

        // Stall: en=0 for three cycles stretches latency by three
        set_ops(0, 7, 9);
        cli.req = 3'b001;
        #1;
        check("stall_gnt", cli.gnt, 3'b001);
        tick();
        cli.req = '0;
        check("stall_mult_valid", mult_valid, 1'b1);
        tick();
        en      = 1'b0;
        cli.req = 3'b001;
        #1;
        check("stall_gnt_gated", cli.gnt, 3'b000);
        check("stall_clken", mult_clken, 1'b0);
        repeat (3) tick();
        en      = 1'b1;
        cli.req = '0;
        #1;
        check("stall_clken_on", mult_clken, 1'b1);
        repeat (4) tick();
        check("stall_rsp_early", cli.rsp_valid, 3'b000);
        tick();
        check("stall_rsp_valid", cli.rsp_valid, 3'b001);
        check("stall_rsp_result", cli.rsp_result, fill(63));
        en = 1'b0;
        tick();
        check("stall_rsp_hold", cli.rsp_valid, 3'b001);
        en = 1'b1;
        tick();
        check("stall_rsp_clear", cli.rsp_valid, 3'b000);

        // Reset mid-flight discards every in-flight operation
        cli.req = 3'b111;
        repeat (3) tick();
        cli.req = '0;
        tick();
        rst = 1'b0;
        #1;
        check("rstmid_mult_valid", mult_valid, 1'b0);
        check("rstmid_busy", cli.busy, 1'b0);
        check("rstmid_rsp_valid", cli.rsp_valid, 3'b000);
        check("rstmid_mult_dataa", mult_dataa, fill(0));
        check("rstmid_rsp_result", cli.rsp_result, fill(0));
        repeat (2) tick();
        @(negedge clk);
        rst     = 1'b1;
        strobes = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (cli.rsp_valid != '0) strobes++;
        end
        check("rstmid_no_strobe", strobes, 0);
        cli.req = 3'b110;
        #1;
        check("rstmid_first_gnt", cli.gnt, 3'b010);
        tick();
        cli.req = '0;
        repeat (8) tick();
        check("final_busy", cli.busy, 1'b0);
        check("final_rsp_valid", cli.rsp_valid, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
